// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: combinational hit/instruction path
// and an IDLE / MEM_READ / UPDATE refill engine that fetches one 128-bit block.
module icache_direct #(
    parameter int ADDR_W          = 10,
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         address,
    output logic [31:0]         instruction,
    output logic                busywait,
    output logic                mem_read,
    output logic [ADDR_W-5:0]   mem_address,
    input  logic [127:0]        mem_readdata,
    input  logic                mem_busywait
);

    localparam int IDX_W   = $clog2(NUM_BLOCKS);
    localparam int BLK_W   = ADDR_W - 4;
    localparam int TAG_W   = ADDR_W - IDX_W - 4;
    localparam int BLOCK_W = 32 * WORDS_PER_BLOCK;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BLK_W-1:0]       miss_addr_q, miss_addr_d;
    logic [BLOCK_W-1:0]     fill_data_q, fill_data_d;
    logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]       tag_d  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]     data_q [NUM_BLOCKS];
    logic [BLOCK_W-1:0]     data_d [NUM_BLOCKS];

    logic [TAG_W-1:0]       tag_s;
    logic [IDX_W-1:0]       idx_s;
    logic [1:0]             off_s;
    logic                   hit_s;
    logic [IDX_W-1:0]       fill_idx_s;
    logic [TAG_W-1:0]       fill_tag_s;

    // Bits outside the cached byte range and the byte-in-word bits carry no meaning here.
    logic addr_unused;
    assign addr_unused = ^{address[31:ADDR_W], address[1:0]};

    // Address decode and hit detection on the live fetch address.
    always_comb begin
        tag_s      = address[ADDR_W-1:IDX_W+4];
        idx_s      = address[IDX_W+3:4];
        off_s      = address[3:2];
        fill_idx_s = miss_addr_q[IDX_W-1:0];
        fill_tag_s = miss_addr_q[BLK_W-1:IDX_W];
        hit_s      = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    end

    // Instruction word select; forced to zero on a miss or while reset is held.
    always_comb begin
        if (hit_s && !RESET) begin
            instruction = data_q[idx_s][{off_s, 5'd0} +: 32];
        end else begin
            instruction = 32'd0;
        end
    end

    // Refill FSM: next state, line writes and memory handshake outputs.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_data_d = fill_data_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;

        case (state_q)
            IDLE: begin
                // Stall in the same cycle the missing address appears.
                busywait = ~hit_s & ~RESET;
                if (!hit_s) begin
                    miss_addr_d = address[ADDR_W-1:4];
                    state_d     = MEM_READ;
                end else begin
                    state_d = IDLE;
                end
            end
            MEM_READ: begin
                busywait    = ~RESET;
                mem_read    = 1'b1;
                mem_address = miss_addr_q;
                if (!mem_busywait) begin
                    fill_data_d = mem_readdata;
                    state_d     = UPDATE;
                end else begin
                    state_d = MEM_READ;
                end
            end
            UPDATE: begin
                busywait            = ~RESET;
                valid_d[fill_idx_s] = 1'b1;
                tag_d[fill_idx_s]   = fill_tag_s;
                data_d[fill_idx_s]  = fill_data_q;
                state_d             = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: reset clears every valid bit and aborts any refill in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Tag/data storage and refill buffer; contents are qualified by valid bits only.
    always_ff @(posedge CLK) begin
        fill_data_q <= fill_data_d;
        tag_q       <= tag_d;
        data_q      <= data_d;
    end

endmodule
